// File: rtl/cfg_bank_arbiter_if.sv
// Requester-side bus of cfg_bank_arbiter: per-requester req/we/addr/wdata in,
// one-hot ack/err pulses and shared read-back data out.
interface cfg_bank_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        err;
  logic [DATA_W-1:0]         rdata;

  modport master (output req, we, addr, wdata, input  ack, err, rdata);
  modport slave  (input  req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/cfg_bank_arbiter.sv
// Round-robin arbiter sharing the 8x16 config register bank between NUM_REQ requesters.
// Optional write protection of addr >= PROT_BASE for requesters 1.. via CFG_BANK_ARB_WRPROT_EN.
module cfg_bank_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PROT_BASE = 6
) (
  input  logic              clk,
  input  logic              reset,
  cfg_bank_arbiter_if.slave req_if,
  output logic              busy,
  output logic              bank_write,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_data_in,
  input  logic [DATA_W-1:0] bank_data_out
);

  localparam int unsigned IDX_W = (NUM_REQ > 2) ? 2 : 1;

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("cfg_bank_arbiter: NUM_REQ must be 2..4");
  end
  if (PROT_BASE >= (1 << ADDR_W)) begin : g_bad_prot_base
    $error("cfg_bank_arbiter: PROT_BASE outside the bank");
  end

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] ack_q;
  logic [DATA_W-1:0]  rdata_q;

  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  // Offsets are scanned from farthest to nearest so the nearest set bit from rr_ptr wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(rr_ptr) + NUM_REQ - 1 - i) % NUM_REQ);
      if (req_if.req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_we    = req_if.we[i];
        sel_addr  = req_if.addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_if.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef CFG_BANK_ARB_WRPROT_EN
  logic               sel_blocked;
  logic               blocked_q;
  logic [NUM_REQ-1:0] err_q;

  assign sel_blocked = sel_we && (sel_idx != '0) && (32'(sel_addr) >= PROT_BASE);
  assign req_if.err  = err_q;
`else
  assign req_if.err  = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      busy         <= 1'b0;
      bank_write   <= 1'b0;
      bank_addr    <= '0;
      bank_data_in <= '0;
`ifdef CFG_BANK_ARB_WRPROT_EN
      blocked_q    <= 1'b0;
      err_q        <= '0;
`endif
    end else begin
      ack_q <= '0;
`ifdef CFG_BANK_ARB_WRPROT_EN
      err_q <= '0;
`endif
      case (state)
        IDLE: begin
          if (sel_valid) begin
            owner        <= sel_idx;
            bank_addr    <= sel_addr;
            bank_data_in <= sel_wdata;
`ifdef CFG_BANK_ARB_WRPROT_EN
            bank_write   <= sel_we && !sel_blocked;
            blocked_q    <= sel_blocked;
`else
            bank_write   <= sel_we;
`endif
            busy         <= 1'b1;
            state        <= GRANT;
          end
        end
        GRANT: begin
          bank_write <= 1'b0;
          state      <= DONE;
        end
        DONE: begin
          // Bank read port is registered, so its output already shows the post-write value here.
          rdata_q      <= bank_data_out;
          ack_q[owner] <= 1'b1;
`ifdef CFG_BANK_ARB_WRPROT_EN
          err_q[owner] <= blocked_q;
`endif
          rr_ptr       <= next_ptr;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_if.ack   = ack_q;
  assign req_if.rdata = rdata_q;

endmodule

// File: tb/tb_cfg_bank_arbiter.sv
// Directed bench for cfg_bank_arbiter with a registered-read 8x16 bank model.
// Expectations follow the CFG_BANK_ARB_WRPROT_EN build setting.
module tb_cfg_bank_arbiter;

  logic        clk;
  logic        reset;
  logic        busy;
  logic        bank_write;
  logic [2:0]  bank_addr;
  logic [15:0] bank_data_in;
  logic [15:0] bank_data_out;

  int checks = 0;
  int errors = 0;

  cfg_bank_arbiter_if #(.NUM_REQ(2), .ADDR_W(3), .DATA_W(16)) bus ();

  cfg_bank_arbiter #(.NUM_REQ(2), .ADDR_W(3), .DATA_W(16), .PROT_BASE(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_if        (bus),
    .busy          (busy),
    .bank_write    (bank_write),
    .bank_addr     (bank_addr),
    .bank_data_in  (bank_data_in),
    .bank_data_out (bank_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank: write-first, registered read.
  logic [15:0] mem [8];
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    mem[0] = 16'hFFFF;
    mem[4] = 16'hABCD;
    mem[7] = 16'h0001;
  end
  always @(posedge clk) begin
    if (bank_write) begin
      mem[bank_addr] <= bank_data_in;
      bank_data_out  <= bank_data_in;
    end else begin
      bank_data_out  <= mem[bank_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic w, input logic [2:0] a, input logic [15:0] d);
    bus.req[r]           = 1'b1;
    bus.we[r]            = w;
    bus.addr[r*3 +: 3]   = a;
    bus.wdata[r*16 +: 16] = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Single uncontended transaction from requester r; checks latency, bank strobe, busy, ack/err/rdata.
  task automatic txn(input string tag, input int r, input logic w, input logic [2:0] a,
                     input logic [15:0] d, input logic [15:0] exp_rd, input logic exp_err,
                     input int exp_bw);
    int  n_bw   = 0;
    int  n_busy = 0;
    int  lat    = 0;
    logic [1:0] ack_seen = '0;
    logic [1:0] err_seen = '0;
    logic [15:0] rd_seen = '0;
    drive(r, w, a, d);
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      tick();
      if (bank_write) begin
        n_bw++;
        check({tag, "_baddr"}, 32'(bank_addr), 32'(a));
        check({tag, "_bdata"}, 32'(bank_data_in), 32'(d));
      end
      if (busy) n_busy++;
      if (bus.ack != 2'b00) begin
        lat      = i;
        ack_seen = bus.ack;
        err_seen = bus.err;
        rd_seen  = bus.rdata;
      end
    end
    bus.req[r] = 1'b0;
    check({tag, "_lat"},   32'(lat), 32'd3);
    check({tag, "_ack"},   32'(ack_seen), 32'(1) << r);
    check({tag, "_err"},   32'(err_seen), exp_err ? (32'(1) << r) : 32'd0);
    check({tag, "_rdata"}, 32'(rd_seen), 32'(exp_rd));
    check({tag, "_bw"},    32'(n_bw), 32'(exp_bw));
    check({tag, "_busy"},  32'(n_busy), 32'd2);
  endtask

  initial begin : main
    int t0, t1, dual, k, first1, n_ack;
    logic [1:0] order [4];

    reset     = 1'b0;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (2) tick();

    check("rst_ack",   32'(bus.ack), 32'd0);
    check("rst_err",   32'(bus.err), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_bw",    32'(bank_write), 32'd0);
    check("rst_baddr", 32'(bank_addr), 32'd0);
    check("rst_bdin",  32'(bank_data_in), 32'd0);
    check("rst_state", 32'(dut.state), 32'd0);
    check("rst_rrptr", 32'(dut.rr_ptr), 32'd0);
    reset = 1'b1;

    txn("rd0", 0, 1'b0, 3'd0, 16'h0000, 16'hFFFF, 1'b0, 0);
    txn("rd4", 0, 1'b0, 3'd4, 16'h0000, 16'hABCD, 1'b0, 0);
    txn("rd7", 0, 1'b0, 3'd7, 16'h0000, 16'h0001, 1'b0, 0);
    txn("wr2", 0, 1'b1, 3'd2, 16'h1234, 16'h1234, 1'b0, 1);

    // Simultaneous writes from a fresh reset: requester 0 first, requester 1 three cycles later.
    do_reset();
    drive(0, 1'b1, 3'd1, 16'hAAAA);
    drive(1, 1'b1, 3'd1, 16'h5555);
    t0 = 0; t1 = 0; dual = 0;
    for (int i = 1; i <= 15 && (t0 == 0 || t1 == 0); i++) begin
      tick();
      if (bus.ack == 2'b11) dual++;
      if (bus.ack[0] && t0 == 0) begin t0 = i; bus.req[0] = 1'b0; end
      if (bus.ack[1] && t1 == 0) begin t1 = i; bus.req[1] = 1'b0; end
    end
    bus.req = '0;
    check("sim_t0",   32'(t0), 32'd3);
    check("sim_t1",   32'(t1), 32'd6);
    check("sim_dual", 32'(dual), 32'd0);
    txn("sim_rd1", 0, 1'b0, 3'd1, 16'h0000, 16'h5555, 1'b0, 0);

    // Requester 0 hogs with back-to-back writes to addr 5; requester 1 keeps re-requesting reads.
    drive(0, 1'b1, 3'd5, 16'h1000);
    k = 0; first1 = 0; dual = 0;
    for (int i = 0; i < 4; i++) order[i] = 2'b00;
    for (int i = 1; i <= 30 && k < 4; i++) begin
      tick();
      if (i == 1) drive(1, 1'b0, 3'd4, 16'h0000);
      if (bus.ack == 2'b11) dual++;
      if (bus.ack != 2'b00) begin
        order[k] = bus.ack;
        if (bus.ack[1] && first1 == 0) first1 = i;
        if (bus.ack[0]) bus.wdata[15:0] = bus.wdata[15:0] + 16'h0001;
        k++;
      end
    end
    bus.req = '0;
    check("alt_g0",   32'(order[0]), 32'd1);
    check("alt_g1",   32'(order[1]), 32'd2);
    check("alt_g2",   32'(order[2]), 32'd1);
    check("alt_g3",   32'(order[3]), 32'd2);
    check("alt_wait", 32'(first1 - 1), 32'd5);
    check("alt_dual", 32'(dual), 32'd0);
    txn("alt_rd5", 0, 1'b0, 3'd5, 16'h0000, 16'h1001, 1'b0, 0);

    // Reset in GRANT of a write: everything clears at once, nothing lands in the bank.
    drive(0, 1'b1, 3'd3, 16'hBEEF);
    tick();
    check("mrst_pre_bw", 32'(bank_write), 32'd1);
    reset = 1'b0;
    #1;
    check("mrst_bw",    32'(bank_write), 32'd0);
    check("mrst_busy",  32'(busy), 32'd0);
    check("mrst_baddr", 32'(bank_addr), 32'd0);
    check("mrst_bdin",  32'(bank_data_in), 32'd0);
    check("mrst_ack",   32'(bus.ack), 32'd0);
    check("mrst_rdata", 32'(bus.rdata), 32'd0);
    tick();
    bus.req = '0;
    reset   = 1'b1;
    check("mrst_state", 32'(dut.state), 32'd0);
    check("mrst_rrptr", 32'(dut.rr_ptr), 32'd0);
    n_ack = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ack != 2'b00) n_ack++;
    end
    check("mrst_noack", 32'(n_ack), 32'd0);
    txn("mrst_rd3", 0, 1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0, 0);

`ifdef CFG_BANK_ARB_WRPROT_EN
    txn("prot_r1", 1, 1'b1, 3'd7, 16'h00FF, 16'h0001, 1'b1, 0);
    txn("prot_r0", 0, 1'b1, 3'd7, 16'h00FF, 16'h00FF, 1'b0, 1);
`else
    txn("prot_r1", 1, 1'b1, 3'd7, 16'h00FF, 16'h00FF, 1'b0, 1);
    txn("prot_r0", 0, 1'b1, 3'd7, 16'h00FF, 16'h00FF, 1'b0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_bank_arbiter.md
Name: cfg_bank_arbiter

Overview:
- Shares the 8-entry x 16-bit configuration register bank (adc0_reg .. digital_config) between NUM_REQ requesters, e.g. host bus, power-on init sequencer and test controller.
- Round-robin arbitration with a req/ack handshake.
- Drives the bank's write/address/data_in and returns the bank's data_out as read-back.
- Sits between the requesters and the bank; it is the only driver of the bank's write port.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 3, bank address width (8 registers).
- DATA_W, 16, register width.
- PROT_BASE, 6, first write-protected address (amp_gain); used only with the optional feature.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request; held until its ack.
- we  in  NUM_REQ  per-requester write enable (1 = write, 0 = read).
- addr  in  NUM_REQ*ADDR_W  per-requester address, requester i at slice i.
- wdata  in  NUM_REQ*DATA_W  per-requester write data, slice i.
- ack  out  NUM_REQ  one-cycle completion pulse to the owner.
- rdata  out  DATA_W  read-back data, valid when any ack bit is high.
- err  out  NUM_REQ  one-cycle error pulse, coincident with ack.
- busy  out  1  high in GRANT and DONE.
- bank_write  out  1  to bank write.
- bank_addr  out  ADDR_W  to bank address.
- bank_data_in  out  DATA_W  to bank data_in.
- bank_data_out  in  DATA_W  from bank data_out; reflects the addressed register one cycle after the address is presented.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, owner=0.
  - ack, err, rdata, bank_write, bank_addr, bank_data_in all 0; busy=0.
  - Reset asserted mid-transaction abandons it: no ack, and bank_write drops immediately.
- FSM:
  - IDLE: if any req bit is set, select the first set bit searching from rr_ptr upward, wrapping mod NUM_REQ. Register owner, bank_addr, bank_data_in=wdata[owner], bank_write=we[owner]. Go to GRANT.
  - GRANT (1 cycle): bank signals are stable; the bank captures a write on the closing edge. Then bank_write=0 and the state goes to DONE. bank_addr is held.
  - DONE (1 cycle): rdata<=bank_data_out (post-write value for writes, i.e. write read-back). ack[owner]=1 for this cycle. rr_ptr<=(owner+1) mod NUM_REQ. Return to IDLE.
- Latency: req sampled high at edge N gives GRANT at N+1 and ack at N+2.
- Throughput: one transaction per 3 cycles minimum.
- The owner must drop req, or present a new request, in the cycle after ack. A req still high in IDLE is treated as a new request.
- Requester inputs are sampled only in IDLE. Changes during GRANT/DONE are ignored.
- bank_write is high for exactly one cycle per write and never during a read.
- rdata holds its last value between acks.
- Only one ack bit is ever high at a time.
- Simultaneous requests: served in rr_ptr order; no requester waits more than NUM_REQ-1 transactions.
- A req bit that drops before grant is simply not served; there is no error.
- Without the optional feature, err is tied to 0.

Optional Feature:
- Macro: CFG_BANK_ARB_WRPROT_EN.
- Defined:
  - Writes from any requester other than 0 to addr >= PROT_BASE are blocked: bank_write stays 0 in GRANT.
  - DONE still occurs: ack[owner]=1, err[owner]=1, rdata = current unchanged register value.
  - Reads are never blocked. Requester 0 is unrestricted.
- Undefined: no protection; err is constant 0; no protection logic is synthesized.

Test Plan:
- After reset, req[0]=1, we=0, addr=0 → ack[0] two cycles later, rdata=16'hFFFF. Then addr=4 → rdata=16'hABCD; addr=7 → rdata=16'h0001.
- req[0] write addr=2, wdata=16'h1234 → bank_write high exactly 1 cycle with bank_addr=2, bank_data_in=16'h1234; ack[0] with rdata=16'h1234; busy high 2 cycles.
- req[0] and req[1] both asserted after reset (both writes, addr 1, wdata 16'hAAAA/16'h5555) → ack[0] first, ack[1] 3 cycles later. Final read of addr 1 = 16'h5555. Never two ack bits high together.
- req[0] held continuously with repeated writes while req[1] pending → grants alternate 0,1,0,1. req[1] acked within 6 cycles of asserting.
- reset pulled low during GRANT of a write (addr 3, 16'hBEEF) → bank_write and all outputs 0 immediately, no ack; after release state=IDLE, rr_ptr=0.
- With CFG_BANK_ARB_WRPROT_EN: req[1] writes addr 7, 16'h00FF → bank_write never high, ack[1]=err[1]=1, rdata=16'h0001. Same write from req[0] → err=0, rdata=16'h00FF. Without the macro: req[1]'s write succeeds and err stays 0.
